mux_onehot_pipe: RTL and testbench
==================================

MUX_ONEHOT_PIPE -- requirements
Module: mux_onehot_pipe

Interface
REQ-001 Parameter WIDTH, default 16: data width per channel, >=1.
REQ-002 Parameter N, default 3: channel count, >=2.
REQ-003 Parameter OR_MODE, default 1: 1 = OR all enabled channels; 0 = lowest-index enabled channel only.
REQ-004 Parameter CNT_W, default 8: violation counter width, >=1.
REQ-005 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 Port rst_n  input  1  synchronous, active-low reset.
REQ-007 Port in  input  [N][WIDTH]  channel data.
REQ-008 Port en  input  N  channel select; one-hot expected.
REQ-009 Port in_valid  input  1  upstream offers in/en.
REQ-010 Port in_ready  output  1  block accepts this cycle.
REQ-011 Port out  output  WIDTH  registered mux result.
REQ-012 Port out_sel  output  N  registered copy of the accepted en, after OR_MODE resolution.
REQ-013 Port out_valid  output  1  out/out_sel hold a result.
REQ-014 Port out_ready  input  1  downstream accepts.
REQ-015 Port clr_err  input  1  clears error state.
REQ-016 Port err_multi  output  1  sticky: an accepted en had more than one bit set.
REQ-017 Port err_zero  output  1  sticky: an accepted en had no bits set.
REQ-018 Port err_cnt  output  CNT_W  saturating count of accepted violations.

Function
REQ-019 Accept SHALL be defined as in_valid && in_ready.
REQ-020 in_ready SHALL equal (!out_valid || out_ready) && rst_n, combinationally.
REQ-021 On accept, out SHALL load the mux result one cycle later (latency 1), and out_valid SHALL be 1.
REQ-022 OR_MODE=1: result = bitwise OR of in[i] over all i with en[i]=1; out_sel = en.
REQ-023 OR_MODE=0: result = in[k], where k is the lowest index with en[k]=1; out_sel = one-hot of k.
REQ-024 en=0 on accept: out SHALL load all zeros and out_sel SHALL load 0 (both modes).
REQ-025 out_valid && !out_ready: out, out_sel and out_valid SHALL hold unchanged; no accept occurs.
REQ-026 out_valid && out_ready && !in_valid: out_valid SHALL go to 0 next cycle; out and out_sel SHALL hold their last values.
REQ-027 out_ready && in_valid with out_valid=1: the old result drains and the new one loads in the same cycle, so full throughput is 1 per cycle with no bubble.
REQ-028 in and en SHALL be ignored in any cycle without an accept; errors SHALL be evaluated only on accept.
REQ-029 Accept with popcount(en)>1 SHALL set err_multi next cycle, in both modes.
REQ-030 Accept with en=0 SHALL set err_zero next cycle.
REQ-031 Each violating accept SHALL increment err_cnt by 1; err_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-032 clr_err=1 SHALL clear err_multi, err_zero and err_cnt to 0 next cycle.
REQ-033 clr_err coinciding with a violating accept: the flag for that violation SHALL be 1 and err_cnt SHALL be 1 next cycle (set wins).
REQ-034 The data path SHALL contain no latches, and out_comb-style intermediates SHALL be fully assigned every cycle.

Reset
REQ-035 rst_n=0 at a clock edge SHALL set out=0, out_sel=0, out_valid=0, err_multi=0, err_zero=0 and err_cnt=0.
REQ-036 While rst_n=0, in_ready SHALL be 0 and no accept SHALL occur.
REQ-037 Reset asserted while a result is held (out_valid=1, out_ready=0) SHALL discard that result.
REQ-038 The first accept is possible in the first cycle after rst_n returns to 1.

Verification (WIDTH=16, N=3, CNT_W=8 unless stated)
REQ-039 OR_MODE=1, in={0x0001,0x0010,0x0100}, en=3'b010, in_valid=1, out_ready=1 -> next cycle out=0x0010, out_sel=3'b010, out_valid=1, no error flags.
REQ-040 OR_MODE=1, en=3'b101, same in -> out=0x0101, err_multi=1, err_cnt=1. With OR_MODE=0 -> out=0x0001, out_sel=3'b001, err_multi=1.
REQ-041 Hold result 0x0010, then out_ready=0 for 3 cycles with new in_valid -> in_ready=0, out stays 0x0010. Then out_ready=1 -> new value loads in that cycle, with no bubble.
REQ-042 en=0 accepted -> out=0x0000, out_sel=0, err_zero=1. Then clr_err=1 together with an en=3'b011 accept -> err_zero=0, err_multi=1, err_cnt=1.
REQ-043 CNT_W=2, 5 violating accepts -> err_cnt reads 1,2,3,3,3.
REQ-044 rst_n=0 while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out=0 and all error state is 0; in_ready=0 during reset and 1 in the first cycle after release.

Source files
------------

// File: rtl/mux_onehot_pipe.sv
// One-hot (or OR-combining) channel mux with a single registered output stage and sticky select-error tracking.
// Latency 1; in_ready drops only while a held result is not being drained (full throughput when out_ready=1).
module mux_onehot_pipe #(
  parameter int WIDTH   = 16,
  parameter int N       = 3,
  parameter int OR_MODE = 1,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N-1:0][WIDTH-1:0]   in,
  input  logic [N-1:0]              en,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out,
  output logic [N-1:0]              out_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      clr_err,
  output logic                      err_multi,
  output logic                      err_zero,
  output logic [CNT_W-1:0]          err_cnt
);

  logic             accept;
  logic [WIDTH-1:0] mux_res;
  logic [N-1:0]     sel_res;
  logic             is_multi;
  logic             is_zero;
  logic             viol;

  assign in_ready = (!out_valid || out_ready) && rst_n;
  assign accept   = in_valid && in_ready;
  assign is_multi = |(en & (en - N'(1)));
  assign is_zero  = ~|en;
  assign viol     = accept && (is_multi || is_zero);

  always_comb begin
    mux_res = '0;
    sel_res = '0;
    if (OR_MODE != 0) begin
      sel_res = en;
      for (int i = 0; i < N; i++) begin
        if (en[i]) mux_res = mux_res | in[i];
      end
    end else begin
      // Walk downward so the lowest enabled index is the last write.
      for (int i = N - 1; i >= 0; i--) begin
        if (en[i]) begin
          mux_res = in[i];
          sel_res = N'(1) << i;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      out       <= mux_res;
      out_sel   <= sel_res;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A violation in the same cycle as clr_err still registers (set wins).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_multi <= 1'b0;
      err_zero  <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_multi <= (err_multi && !clr_err) || (accept && is_multi);
      err_zero  <= (err_zero && !clr_err) || (accept && is_zero);
      if (clr_err)
        err_cnt <= viol ? CNT_W'(1) : '0;
      else if (viol && !(&err_cnt))
        err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mux_onehot_pipe.sv
// Bench for mux_onehot_pipe: three instances (OR mode, priority mode, 2-bit counter) on shared stimulus, checked against a reference model.
module tb_mux_onehot_pipe;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [2:0][15:0]  in_d = '0;
  logic [2:0]        en = '0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic              clr_err = 1'b0;

  logic [15:0] o_out [3];
  logic [2:0]  o_sel [3];
  logic        o_vld [3];
  logic        o_rdy [3];
  logic        o_multi [3];
  logic        o_zero [3];
  logic [7:0]  o_cnt [2];
  logic [1:0]  o_cnt2;
  logic [31:0] d_cnt [3];

  // Reference model state, per instance
  logic [15:0] m_out [3];
  logic [2:0]  m_sel [3];
  logic        m_vld;
  logic        m_multi [3];
  logic        m_zero [3];
  logic [31:0] m_cnt [3];
  bit          mode [3] = '{1'b1, 1'b0, 1'b1};
  int          maxc [3] = '{255, 255, 3};

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mux_onehot_pipe #(.WIDTH(16), .N(3), .OR_MODE(1), .CNT_W(8)) u_or (
    .clk(clk), .rst_n(rst_n), .in(in_d), .en(en), .in_valid(in_valid), .in_ready(o_rdy[0]),
    .out(o_out[0]), .out_sel(o_sel[0]), .out_valid(o_vld[0]), .out_ready(out_ready),
    .clr_err(clr_err), .err_multi(o_multi[0]), .err_zero(o_zero[0]), .err_cnt(o_cnt[0]));

  mux_onehot_pipe #(.WIDTH(16), .N(3), .OR_MODE(0), .CNT_W(8)) u_pri (
    .clk(clk), .rst_n(rst_n), .in(in_d), .en(en), .in_valid(in_valid), .in_ready(o_rdy[1]),
    .out(o_out[1]), .out_sel(o_sel[1]), .out_valid(o_vld[1]), .out_ready(out_ready),
    .clr_err(clr_err), .err_multi(o_multi[1]), .err_zero(o_zero[1]), .err_cnt(o_cnt[1]));

  mux_onehot_pipe #(.WIDTH(16), .N(3), .OR_MODE(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in(in_d), .en(en), .in_valid(in_valid), .in_ready(o_rdy[2]),
    .out(o_out[2]), .out_sel(o_sel[2]), .out_valid(o_vld[2]), .out_ready(out_ready),
    .clr_err(clr_err), .err_multi(o_multi[2]), .err_zero(o_zero[2]), .err_cnt(o_cnt2));

  always_comb begin
    d_cnt[0] = 32'(o_cnt[0]);
    d_cnt[1] = 32'(o_cnt[1]);
    d_cnt[2] = 32'(o_cnt2);
  end

  // Expected mux result straight from the selection rules.
  function automatic void ref_mux(input bit orm, input logic [2:0] e, input logic [2:0][15:0] d,
                                  output logic [15:0] r, output logic [2:0] s);
    r = 16'h0;
    s = 3'b000;
    if (orm) begin
      s = e;
      for (int i = 0; i < 3; i++) if (e[i]) r = r | d[i];
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (e[i]) begin
          r = d[i];
          s = 3'b000;
          s[i] = 1'b1;
          break;
        end
      end
    end
  endfunction

  // Advance one clock, updating the model from the inputs presented this cycle.
  task automatic step();
    bit acc;
    bit bad_multi;
    bit bad_zero;
    logic [15:0] r;
    logic [2:0] s;
    acc = rst_n && in_valid && (!m_vld || out_ready);
    bad_multi = $countones(en) > 1;
    bad_zero = (en == 3'b000);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_out[k] = '0; m_sel[k] = '0; m_multi[k] = 0; m_zero[k] = 0; m_cnt[k] = 0;
      end else begin
        if (clr_err) begin
          m_multi[k] = 0; m_zero[k] = 0; m_cnt[k] = 0;
        end
        if (acc) begin
          ref_mux(mode[k], en, in_d, r, s);
          m_out[k] = r;
          m_sel[k] = s;
          if (bad_multi) m_multi[k] = 1;
          if (bad_zero) m_zero[k] = 1;
          if ((bad_multi || bad_zero) && m_cnt[k] < 32'(maxc[k])) m_cnt[k] = m_cnt[k] + 1;
        end
      end
    end
    if (!rst_n) m_vld = 0;
    else if (acc) m_vld = 1;
    else if (out_ready) m_vld = 0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 1; out_ready = 1; en = 3'b001;
    step(); step();
    n_chk++; if (o_rdy[0] !== 1'b0) $display("FAIL reset_in_ready got %b want 0", o_rdy[0]); else n_pass++;
    n_chk++; if (o_vld[0] !== 1'b0) $display("FAIL reset_out_valid got %b want 0", o_vld[0]); else n_pass++;
    n_chk++; if (o_out[0] !== 16'h0) $display("FAIL reset_out got %h want 0000", o_out[0]); else n_pass++;
    n_chk++; if (o_cnt[0] !== 8'h0 || o_multi[0] !== 1'b0 || o_zero[0] !== 1'b0)
      $display("FAIL reset_err got cnt=%0d multi=%b zero=%b want 0/0/0", o_cnt[0], o_multi[0], o_zero[0]); else n_pass++;
    rst_n = 1; in_valid = 0;
    #1;
    n_chk++; if (o_rdy[0] !== 1'b1) $display("FAIL release_in_ready got %b want 1", o_rdy[0]); else n_pass++;
  endtask

  task automatic test_basic();
    in_d[0] = 16'h0001; in_d[1] = 16'h0010; in_d[2] = 16'h0100;
    en = 3'b010; in_valid = 1; out_ready = 1;
    step();
    n_chk++; if (o_out[0] !== 16'h0010) $display("FAIL basic_out got %h want 0010", o_out[0]); else n_pass++;
    n_chk++; if (o_sel[0] !== 3'b010) $display("FAIL basic_sel got %b want 010", o_sel[0]); else n_pass++;
    n_chk++; if (o_vld[0] !== 1'b1) $display("FAIL basic_valid got %b want 1", o_vld[0]); else n_pass++;
    n_chk++; if (o_multi[0] !== 1'b0 || o_zero[0] !== 1'b0) $display("FAIL basic_noerr got multi=%b zero=%b want 0/0", o_multi[0], o_zero[0]); else n_pass++;
    en = 3'b101;
    step();
    n_chk++; if (o_out[0] !== 16'h0101) $display("FAIL or_multi_out got %h want 0101", o_out[0]); else n_pass++;
    n_chk++; if (o_multi[0] !== 1'b1 || o_cnt[0] !== 8'd1) $display("FAIL or_multi_err got multi=%b cnt=%0d want 1/1", o_multi[0], o_cnt[0]); else n_pass++;
    n_chk++; if (o_out[1] !== 16'h0001) $display("FAIL pri_out got %h want 0001", o_out[1]); else n_pass++;
    n_chk++; if (o_sel[1] !== 3'b001) $display("FAIL pri_sel got %b want 001", o_sel[1]); else n_pass++;
    n_chk++; if (o_multi[1] !== 1'b1) $display("FAIL pri_multi got %b want 1", o_multi[1]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    en = 3'b010; in_valid = 1; out_ready = 1;
    step();
    out_ready = 0; en = 3'b100;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_chk++; if (o_rdy[0] !== 1'b0) $display("FAIL stall_in_ready cyc%0d got %b want 0", c, o_rdy[0]); else n_pass++;
      step();
      n_chk++; if (o_out[0] !== 16'h0010 || o_vld[0] !== 1'b1) $display("FAIL stall_hold cyc%0d got %h/%b want 0010/1", c, o_out[0], o_vld[0]); else n_pass++;
    end
    out_ready = 1;
    #1;
    n_chk++; if (o_rdy[0] !== 1'b1) $display("FAIL drain_in_ready got %b want 1", o_rdy[0]); else n_pass++;
    step();
    n_chk++; if (o_out[0] !== 16'h0100 || o_vld[0] !== 1'b1) $display("FAIL drain_load got %h/%b want 0100/1", o_out[0], o_vld[0]); else n_pass++;
    en = 3'b001;
    step();
    n_chk++; if (o_out[0] !== 16'h0001 || o_vld[0] !== 1'b1) $display("FAIL no_bubble got %h/%b want 0001/1", o_out[0], o_vld[0]); else n_pass++;
    in_valid = 0;
    step();
    n_chk++; if (o_vld[0] !== 1'b0 || o_out[0] !== 16'h0001) $display("FAIL empty_hold got %h/%b want 0001/0", o_out[0], o_vld[0]); else n_pass++;
  endtask

  task automatic test_zero_clr();
    clr_err = 1; in_valid = 0;
    step();
    n_chk++; if (o_cnt[0] !== 8'd0 || o_multi[0] !== 1'b0) $display("FAIL clr_only got cnt=%0d multi=%b want 0/0", o_cnt[0], o_multi[0]); else n_pass++;
    clr_err = 0; en = 3'b000; in_valid = 1;
    step();
    n_chk++; if (o_out[0] !== 16'h0 || o_sel[0] !== 3'b000) $display("FAIL zero_out got %h/%b want 0000/000", o_out[0], o_sel[0]); else n_pass++;
    n_chk++; if (o_zero[0] !== 1'b1 || o_cnt[0] !== 8'd1) $display("FAIL zero_err got zero=%b cnt=%0d want 1/1", o_zero[0], o_cnt[0]); else n_pass++;
    n_chk++; if (o_out[1] !== 16'h0 || o_zero[1] !== 1'b1) $display("FAIL pri_zero got %h/%b want 0000/1", o_out[1], o_zero[1]); else n_pass++;
    clr_err = 1; en = 3'b011;
    step();
    clr_err = 0;
    n_chk++; if (o_zero[0] !== 1'b0 || o_multi[0] !== 1'b1 || o_cnt[0] !== 8'd1)
      $display("FAIL clr_vs_set got zero=%b multi=%b cnt=%0d want 0/1/1", o_zero[0], o_multi[0], o_cnt[0]); else n_pass++;
    n_chk++; if (o_out[0] !== 16'h0011 || o_out[1] !== 16'h0001) $display("FAIL clr_vs_set_data got %h/%h want 0011/0001", o_out[0], o_out[1]); else n_pass++;
  endtask

  task automatic test_saturate();
    logic [1:0] want2 [5];
    want2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    clr_err = 1; in_valid = 0;
    step();
    clr_err = 0; in_valid = 1; out_ready = 1;
    for (int v = 0; v < 5; v++) begin
      en = (v % 2 == 0) ? 3'b011 : 3'b000;
      step();
      n_chk++; if (o_cnt2 !== want2[v]) $display("FAIL sat_cnt2 #%0d got %0d want %0d", v, o_cnt2, want2[v]); else n_pass++;
      n_chk++; if (o_cnt[0] !== 8'(v + 1)) $display("FAIL sat_cnt8 #%0d got %0d want %0d", v, o_cnt[0], v + 1); else n_pass++;
    end
  endtask

  task automatic test_reset_hold();
    en = 3'b110; in_valid = 1; out_ready = 1;
    step();
    in_valid = 0; out_ready = 0;
    step();
    n_chk++; if (o_vld[0] !== 1'b1) $display("FAIL held_before_reset got %b want 1", o_vld[0]); else n_pass++;
    rst_n = 0;
    #1;
    n_chk++; if (o_rdy[0] !== 1'b0) $display("FAIL in_ready_in_reset got %b want 0", o_rdy[0]); else n_pass++;
    step();
    n_chk++; if (o_vld[0] !== 1'b0 || o_out[0] !== 16'h0 || o_sel[0] !== 3'b000)
      $display("FAIL reset_discard got %h/%b/%b want 0000/000/0", o_out[0], o_sel[0], o_vld[0]); else n_pass++;
    n_chk++; if (o_multi[0] !== 1'b0 || o_zero[0] !== 1'b0 || o_cnt[0] !== 8'd0)
      $display("FAIL reset_err_clear got %b/%b/%0d want 0/0/0", o_multi[0], o_zero[0], o_cnt[0]); else n_pass++;
    rst_n = 1; in_valid = 1; en = 3'b010;
    #1;
    n_chk++; if (o_rdy[0] !== 1'b1) $display("FAIL first_in_ready got %b want 1", o_rdy[0]); else n_pass++;
    step();
    n_chk++; if (o_vld[0] !== 1'b1 || o_out[0] !== 16'h0010) $display("FAIL first_accept got %h/%b want 0010/1", o_out[0], o_vld[0]); else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) in_d[i] = 16'($urandom);
      en        = 3'($urandom_range(0, 7));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      clr_err   = ($urandom_range(0, 19) == 0);
      rst_n     = ($urandom_range(0, 49) != 0);
      #1;
      n_chk++;
      if (o_rdy[0] !== (rst_n && (!m_vld || out_ready)))
        $display("FAIL rnd_in_ready cyc%0d got %b want %b", c, o_rdy[0], rst_n && (!m_vld || out_ready));
      else n_pass++;
      step();
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (o_out[k] !== m_out[k] || o_sel[k] !== m_sel[k] || o_vld[k] !== m_vld)
          $display("FAIL rnd_data cyc%0d dut%0d got %h/%b/%b want %h/%b/%b", c, k,
                   o_out[k], o_sel[k], o_vld[k], m_out[k], m_sel[k], m_vld);
        else n_pass++;
        n_chk++;
        if (o_multi[k] !== m_multi[k] || o_zero[k] !== m_zero[k] || d_cnt[k] !== m_cnt[k])
          $display("FAIL rnd_err cyc%0d dut%0d got %b/%b/%0d want %b/%b/%0d", c, k,
                   o_multi[k], o_zero[k], d_cnt[k], m_multi[k], m_zero[k], m_cnt[k]);
        else n_pass++;
      end
    end
    rst_n = 1; clr_err = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero_clr();
    test_saturate();
    test_reset_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
